// File: rtl/riscv_load_align.sv
// Load alignment unit: issues word reads (one, or two for a boundary-crossing access),
// then extracts and sign/zero-extends the addressed byte, halfword or word.
module riscv_load_align #(
  parameter int unsigned WORD_LENGTH = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   ld_valid_i,
  output logic                   ld_ready_o,
  input  logic [WORD_LENGTH-1:0] ld_addr_i,
  input  logic [1:0]             ld_mask_sel_i,
  input  logic                   ld_unsigned_i,
  output logic                   mem_req_o,
  output logic [WORD_LENGTH-1:0] mem_addr_o,
  input  logic                   mem_gnt_i,
  input  logic                   mem_rvalid_i,
  input  logic [WORD_LENGTH-1:0] mem_rdata_i,
  output logic                   res_valid_o,
  input  logic                   res_ready_i,
  output logic [WORD_LENGTH-1:0] res_data_o,
  output logic                   busy_o
);

  localparam logic [1:0] MaskB = 2'b00;
  localparam logic [1:0] MaskH = 2'b01;
  localparam logic [1:0] MaskX = 2'b10;

  typedef enum logic [2:0] {
    StIdle,
    StReq0,
    StWait0,
    StReq1,
    StWait1,
    StDone
  } state_e;

  state_e                 state_q;
  logic [1:0]             off_q;
  logic [1:0]             sel_q;
  logic                   uns_q;
  logic                   split_q;
  logic [WORD_LENGTH-1:0] lo_q;

  logic                   ld_ready_q;
  logic                   mem_req_q;
  logic [WORD_LENGTH-1:0] mem_addr_q;
  logic                   res_valid_q;
  logic [WORD_LENGTH-1:0] res_data_q;
  logic                   busy_q;

  logic                   split_d;
  logic [WORD_LENGTH-1:0] lo_sel;
  logic [23:0]            hi_sel;
  logic [WORD_LENGTH-1:0] raw;
  logic [WORD_LENGTH-1:0] result_d;

  always_comb begin
    split_d = ((ld_mask_sel_i == MaskH) && (ld_addr_i[1:0] == 2'd3)) ||
              ((ld_mask_sel_i == MaskX) && (ld_addr_i[1:0] != 2'd0));
  end

  // Only the low three bytes of the upper word can ever reach the result.
  always_comb begin
    lo_sel = mem_rdata_i;
    hi_sel = '0;
    if (state_q == StWait1) begin
      lo_sel = lo_q;
      hi_sel = mem_rdata_i[23:0];
    end
    raw = WORD_LENGTH'({hi_sel, lo_sel} >> {off_q, 3'b000});
  end

  always_comb begin
    result_d = '0;
    unique case (sel_q)
      MaskB:   result_d = uns_q ? {24'd0, raw[7:0]} : {{24{raw[7]}}, raw[7:0]};
      MaskH:   result_d = uns_q ? {16'd0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
      MaskX:   result_d = raw;
      default: result_d = '0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      off_q       <= '0;
      sel_q       <= '0;
      uns_q       <= 1'b0;
      split_q     <= 1'b0;
      lo_q        <= '0;
      ld_ready_q  <= 1'b1;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (ld_valid_i) begin
            off_q      <= ld_addr_i[1:0];
            sel_q      <= ld_mask_sel_i;
            uns_q      <= ld_unsigned_i;
            split_q    <= split_d;
            ld_ready_q <= 1'b0;
            mem_req_q  <= 1'b1;
            mem_addr_q <= {ld_addr_i[WORD_LENGTH-1:2], 2'b00};
            busy_q     <= 1'b1;
            state_q    <= StReq0;
          end
        end
        StReq0: begin
          if (mem_gnt_i) begin
            mem_req_q <= 1'b0;
            state_q   <= StWait0;
          end
        end
        StWait0: begin
          if (mem_rvalid_i) begin
            lo_q <= mem_rdata_i;
            if (split_q) begin
              mem_req_q  <= 1'b1;
              // Wraps from the top word to address 0.
              mem_addr_q <= mem_addr_q + WORD_LENGTH'(4);
              state_q    <= StReq1;
            end else begin
              res_valid_q <= 1'b1;
              res_data_q  <= result_d;
              state_q     <= StDone;
            end
          end
        end
        StReq1: begin
          if (mem_gnt_i) begin
            mem_req_q <= 1'b0;
            state_q   <= StWait1;
          end
        end
        StWait1: begin
          if (mem_rvalid_i) begin
            res_valid_q <= 1'b1;
            res_data_q  <= result_d;
            state_q     <= StDone;
          end
        end
        StDone: begin
          if (res_ready_i) begin
            res_valid_q <= 1'b0;
            ld_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: begin
          state_q    <= StIdle;
          ld_ready_q <= 1'b1;
          mem_req_q  <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign ld_ready_o  = ld_ready_q;
  assign mem_req_o   = mem_req_q;
  assign mem_addr_o  = mem_addr_q;
  assign res_valid_o = res_valid_q;
  assign res_data_o  = res_data_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_riscv_load_align.sv
// Directed bench for riscv_load_align: table of loads against a small memory model,
// plus stall, wrap-around and reset-in-flight sequences.
module tb_riscv_load_align;

  logic        clk = 1'b0;
  logic        rst;
  logic        ld_valid;
  logic        ld_ready;
  logic [31:0] ld_addr;
  logic [1:0]  ld_mask_sel;
  logic        ld_unsigned;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  riscv_load_align #(.WORD_LENGTH(32)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .ld_valid_i   (ld_valid),
    .ld_ready_o   (ld_ready),
    .ld_addr_i    (ld_addr),
    .ld_mask_sel_i(ld_mask_sel),
    .ld_unsigned_i(ld_unsigned),
    .mem_req_o    (mem_req),
    .mem_addr_o   (mem_addr),
    .mem_gnt_i    (mem_gnt),
    .mem_rvalid_i (mem_rvalid),
    .mem_rdata_i  (mem_rdata),
    .res_valid_o  (res_valid),
    .res_ready_i  (res_ready),
    .res_data_o   (res_data),
    .busy_o       (busy)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0100: return 32'h80AA_5511;
      32'h0000_2000: return 32'hBEEF_1234;
      32'h0000_1000: return 32'h4433_2211;
      32'h0000_1004: return 32'h8877_6655;
      32'hFFFF_FFFC: return 32'hDDCC_BBAA;
      32'h0000_0000: return 32'h3322_11F0;
      default:       return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Runs one load with a responsive memory; gnt_wait stalls the first request,
  // rdy_wait stalls the result consumer.
  task automatic run_load(input logic [31:0] addr, input logic [1:0] sel, input logic uns,
                          input int gnt_wait, input int rdy_wait,
                          output logic [31:0] data, output int lat, output int nreq,
                          output logic [31:0] a0, output logic [31:0] a1,
                          output logic stable_ok, output logic timeout);
    int          edges = 0;
    int          gcnt = gnt_wait;
    int          rcnt = rdy_wait;
    logic        pend = 1'b0;
    logic [31:0] paddr = '0;
    logic        in_req = 1'b0;
    logic [31:0] held_addr = '0;
    logic        seen_res = 1'b0;
    logic        done = 1'b0;
    data = '0; lat = 0; nreq = 0; a0 = '0; a1 = '0; stable_ok = 1'b1;
    @(negedge clk);
    ld_valid = 1'b1; ld_addr = addr; ld_mask_sel = sel; ld_unsigned = uns;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    ld_valid = 1'b0;
    while (!done && edges < 60) begin
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h5A5A_5A5A; res_ready = 1'b0;
      if (pend) begin
        mem_rvalid = 1'b1; mem_rdata = mem_word(paddr); pend = 1'b0;
      end
      if (mem_req) begin
        if (!in_req) begin
          nreq++;
          if (nreq == 1) a0 = mem_addr; else a1 = mem_addr;
          in_req = 1'b1; held_addr = mem_addr;
        end else if (mem_addr !== held_addr) begin
          stable_ok = 1'b0;
        end
        if (gcnt > 0) gcnt--;
        else begin
          mem_gnt = 1'b1; pend = 1'b1; paddr = mem_addr; in_req = 1'b0;
        end
      end
      if (res_valid) begin
        if (!seen_res) begin
          seen_res = 1'b1; lat = edges; data = res_data;
        end else if (res_data !== data) begin
          stable_ok = 1'b0;
        end
        if (rcnt > 0) rcnt--;
        else begin
          res_ready = 1'b1; done = 1'b1;
        end
      end else if (seen_res) begin
        stable_ok = 1'b0;
      end
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    mem_gnt = 1'b0; mem_rvalid = 1'b0; res_ready = 1'b0;
    timeout = !done;
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  sel;
    logic        uns;
    logic [31:0] exp_data;
    int          lat;
    int          nreq;
    logic [31:0] a0;
    logic [31:0] a1;
  } vec_t;

  vec_t vecs[16];

  initial begin
    logic [31:0] d, a0, a1;
    int          lat, nreq;
    logic        ok, to;

    vecs[0]  = '{32'h0000_0103, 2'd0, 1'b0, 32'hFFFF_FF80, 3, 1, 32'h0000_0100, 32'h0};
    vecs[1]  = '{32'h0000_2002, 2'd1, 1'b1, 32'h0000_BEEF, 3, 1, 32'h0000_2000, 32'h0};
    vecs[2]  = '{32'h0000_1001, 2'd2, 1'b0, 32'h5544_3322, 5, 2, 32'h0000_1000, 32'h1004};
    vecs[3]  = '{32'hFFFF_FFFF, 2'd1, 1'b0, 32'hFFFF_F0DD, 5, 2, 32'hFFFF_FFFC, 32'h0};
    vecs[4]  = '{32'h0000_0103, 2'd0, 1'b1, 32'h0000_0080, 3, 1, 32'h0000_0100, 32'h0};
    vecs[5]  = '{32'h0000_2002, 2'd1, 1'b0, 32'hFFFF_BEEF, 3, 1, 32'h0000_2000, 32'h0};
    vecs[6]  = '{32'h0000_1002, 2'd1, 1'b1, 32'h0000_4433, 3, 1, 32'h0000_1000, 32'h0};
    vecs[7]  = '{32'h0000_1003, 2'd1, 1'b0, 32'h0000_5544, 5, 2, 32'h0000_1000, 32'h1004};
    vecs[8]  = '{32'h0000_1000, 2'd2, 1'b1, 32'h4433_2211, 3, 1, 32'h0000_1000, 32'h0};
    vecs[9]  = '{32'h0000_1004, 2'd0, 1'b0, 32'h0000_0055, 3, 1, 32'h0000_1004, 32'h0};
    vecs[10] = '{32'h0000_1006, 2'd1, 1'b0, 32'hFFFF_8877, 3, 1, 32'h0000_1004, 32'h0};
    vecs[11] = '{32'h0000_1001, 2'd3, 1'b0, 32'h0000_0000, 3, 1, 32'h0000_1000, 32'h0};
    vecs[12] = '{32'h0000_1002, 2'd2, 1'b0, 32'h6655_4433, 5, 2, 32'h0000_1000, 32'h1004};
    vecs[13] = '{32'h0000_1003, 2'd2, 1'b1, 32'h7766_5544, 5, 2, 32'h0000_1000, 32'h1004};
    vecs[14] = '{32'h0000_1001, 2'd0, 1'b0, 32'h0000_0022, 3, 1, 32'h0000_1000, 32'h0};
    vecs[15] = '{32'h0000_2003, 2'd0, 1'b1, 32'h0000_00BE, 3, 1, 32'h0000_2000, 32'h0};

    rst = 1'b1; ld_valid = 1'b0; ld_addr = '0; ld_mask_sel = '0; ld_unsigned = 1'b0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; res_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("reset ld_ready", 32'(ld_ready), 32'd1);
    check("reset mem_req", 32'(mem_req), 32'd0);
    check("reset mem_addr", mem_addr, 32'd0);
    check("reset res_valid", 32'(res_valid), 32'd0);
    check("reset res_data", res_data, 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    rst = 1'b0;

    // Stray gnt/rvalid while idle must be ignored.
    mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    @(negedge clk);
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    check("idle stray res_valid", 32'(res_valid), 32'd0);
    check("idle stray mem_req", 32'(mem_req), 32'd0);

    for (int i = 0; i < 16; i++) begin
      run_load(vecs[i].addr, vecs[i].sel, vecs[i].uns, 0, 0, d, lat, nreq, a0, a1, ok, to);
      check($sformatf("v%0d timeout", i), 32'(to), 32'd0);
      check($sformatf("v%0d res_data", i), d, vecs[i].exp_data);
      check($sformatf("v%0d latency", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("v%0d nreq", i), 32'(nreq), 32'(vecs[i].nreq));
      check($sformatf("v%0d addr0", i), a0, vecs[i].a0);
      if (vecs[i].nreq == 2) check($sformatf("v%0d addr1", i), a1, vecs[i].a1);
      check($sformatf("v%0d back to idle", i), {30'd0, ld_ready, busy}, 32'd2);
    end

    // Stalled grant and stalled consumer on a split word load.
    run_load(32'h0000_1001, 2'd2, 1'b0, 3, 2, d, lat, nreq, a0, a1, ok, to);
    check("stall timeout", 32'(to), 32'd0);
    check("stall held stable", 32'(ok), 32'd1);
    check("stall res_data", d, 32'h5544_3322);
    check("stall latency", 32'(lat), 32'd8);

    // Reset during WAIT1, then a late rvalid.
    @(negedge clk);
    ld_valid = 1'b1; ld_addr = 32'h0000_1001; ld_mask_sel = 2'd2; ld_unsigned = 1'b0;
    @(negedge clk);
    ld_valid = 1'b0; mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = mem_word(32'h1000);
    @(negedge clk);
    mem_rvalid = 1'b0; mem_gnt = 1'b1;
    check("rst seq req1 addr", mem_addr, 32'h0000_1004);
    @(negedge clk);
    mem_gnt = 1'b0;
    check("rst seq in wait1 busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("async rst ld_ready", 32'(ld_ready), 32'd1);
    check("async rst busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = mem_word(32'h1004);
    @(negedge clk);
    mem_rvalid = 1'b0;
    check("late rvalid res_valid", 32'(res_valid), 32'd0);
    check("late rvalid ld_ready", 32'(ld_ready), 32'd1);
    check("late rvalid mem_req", 32'(mem_req), 32'd0);
    run_load(32'h0000_0103, 2'd0, 1'b0, 0, 0, d, lat, nreq, a0, a1, ok, to);
    check("post rst timeout", 32'(to), 32'd0);
    check("post rst res_data", d, 32'hFFFF_FF80);
    check("post rst latency", 32'(lat), 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
